// File: rtl/pc_unit.sv
// Fetch program-counter generator: sequential advance, trap/branch redirects,
// fetch stall, and a circular return-address stack for return prediction.
module pc_unit #(
    parameter int unsigned          XLEN       = 32,
    parameter logic [XLEN-1:0]      RESET_VEC  = '0,
    parameter int unsigned          INST_BYTES = 4,
    parameter int unsigned          RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_enable,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            call_valid,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic [XLEN-1:0]  ras_top;

    assign pc        = pc_q;
    assign pc_plus   = pc_q + XLEN'(INST_BYTES);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);
    assign ras_top   = ras_mem[top_q];

    always_comb begin
        pc_d      = pc_plus;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = top_q;

        if (trap_valid) begin
            pc_d  = trap_vec & ALIGN_MASK;
            cnt_d = '0;
        end else if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
        end else if (!write_enable) begin
            pc_d = pc_q;
        end else if (ret_valid && call_valid && !ras_empty) begin
            // Return into a call: swap the predicted target for our own return address.
            pc_d   = ras_top;
            ras_we = 1'b1;
        end else if (ret_valid && !call_valid) begin
            if (!ras_empty) begin
                pc_d  = ras_top;
                top_d = top_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (call_valid) begin
            // A push when full lands on the oldest slot, so the count saturates.
            pc_d      = call_target & ALIGN_MASK;
            top_d     = top_q + 1'b1;
            ras_we    = 1'b1;
            ras_waddr = top_q + 1'b1;
            if (!ras_full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; the count gates every read that reaches pc.
    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_mem[ras_waddr] <= pc_plus;
        end
    end

endmodule
